// File: rtl/shift_pkg.sv
// Mode encodings shared by the pipelined barrel shifter and its stages.
package shift_pkg;

    typedef logic [1:0] sh_mode_t;

    localparam sh_mode_t SH_LSL = 2'b00;
    localparam sh_mode_t SH_LSR = 2'b01;
    localparam sh_mode_t SH_ASR = 2'b10;
    localparam sh_mode_t SH_ROR = 2'b11;

endpackage

// File: rtl/shift_stage.sv
// One registered log-shifter stage: shifts by 2^K when amount bit K is set,
// and carries mode, amount and the running carry along with the data.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int K     = 0,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  sh_mode_t         mode,
    input  logic [SHW-1:0]   amt,
    input  logic             c,
    output logic [WIDTH-1:0] q,
    output sh_mode_t         q_mode,
    output logic [SHW-1:0]   q_amt,
    output logic             q_c,
    output logic             q_zero
);

    localparam int S = 1 << K;

    logic [WIDTH-1:0] nd;
    logic             nc;

    // NOTE: every output of an always_comb gets a default first so no latch is inferred.
    always_comb begin
        nd = d;
        nc = c;
        if (amt[K]) begin
            case (mode)
                SH_LSL: begin
                    nd = d << S;
                    nc = d[WIDTH-S];
                end
                SH_LSR: begin
                    nd = d >> S;
                    nc = d[S-1];
                end
                SH_ASR: begin
                    nd = $signed(d) >>> S;
                    nc = d[S-1];
                end
                default: begin
                    nd = {d[S-1:0], d[WIDTH-1:S]};
                    nc = 1'b0;
                end
            endcase
        end
    end

    // NOTE: datapath registers are reset too, because out_data and the flags must read 0 after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q      <= '0;
            q_mode <= SH_LSL;
            q_amt  <= '0;
            q_c    <= 1'b0;
            q_zero <= 1'b0;
        end else if (en) begin
            q      <= nd;
            q_mode <= mode;
            q_amt  <= amt;
            q_c    <= nc;
            q_zero <= (nd == '0);
        end
    end

endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter: SHW registered stages, valid/ready on both sides,
// whole-pipeline stall when the output is held.
module shift_unit_pipe #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero
);

    logic             en;
    logic [SHW-1:0]   valid_q;
    logic [WIDTH-1:0] data_a  [SHW+1];
    logic [1:0]       mode_a  [SHW+1];
    logic [SHW-1:0]   amt_a   [SHW+1];
    logic             carry_a [SHW+1];
    logic [SHW-1:0]   zero_v;
    logic             unused_tail;

    // A held result freezes every stage, bubbles included.
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;

    assign data_a[0]  = in_data;
    assign mode_a[0]  = in_mode;
    assign amt_a[0]   = in_amt;
    assign carry_a[0] = 1'b0;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .K     (k),
            .SHW   (SHW)
        ) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (en),
            .d      (data_a[k]),
            .mode   (mode_a[k]),
            .amt    (amt_a[k]),
            .c      (carry_a[k]),
            .q      (data_a[k+1]),
            .q_mode (mode_a[k+1]),
            .q_amt  (amt_a[k+1]),
            .q_c    (carry_a[k+1]),
            .q_zero (zero_v[k])
        );
    end

    // NOTE: sequential state uses non-blocking assignments so all stages advance from the same snapshot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (en) begin
            valid_q <= {valid_q[SHW-2:0], in_valid};
        end
    end

    assign out_valid = valid_q[SHW-1];
    assign out_data  = data_a[SHW];
    assign out_carry = carry_a[SHW];
    assign out_zero  = zero_v[SHW-1];

    // Only the last stage's zero flag is architectural; the tail mode/amount are spent.
    assign unused_tail = ^{mode_a[SHW], amt_a[SHW], zero_v[SHW-2:0]};

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Self-checking bench for shift_unit_pipe: directed vector table, stall and
// reset sequences, and a randomized stream scored against a reference model.
module tb_shift_unit_pipe;
    import shift_pkg::*;

    localparam int WIDTH = 16;
    localparam int SHW   = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic [SHW-1:0]   in_amt = '0;
    logic [1:0]       in_mode = SH_LSL;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic             out_zero;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_emit   = 0;
    int acc_cyc  = 0;
    int emit_cyc = 0;

    typedef struct {
        logic [17:0] res;
        int          key;
    } exp_t;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  amt;
        sh_mode_t    mode;
        logic [15:0] want_data;
        logic        want_carry;
        logic        want_zero;
    } vec_t;

    exp_t sb[$];
    bit   cov[64];

    shift_unit_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
        end
    endtask

    // Reference: shift by n in one go from the mode rules; returns {carry, zero, data}.
    function automatic logic [17:0] model(input logic [15:0] d, input logic [3:0] amt, input logic [1:0] m);
        int          n;
        logic [15:0] r;
        logic        c;
        n = int'(amt);
        r = d;
        c = 1'b0;
        case (m)
            SH_LSL: begin
                r = d << n;
                c = (n == 0) ? 1'b0 : d[16-n];
            end
            SH_LSR: begin
                r = d >> n;
                c = (n == 0) ? 1'b0 : d[n-1];
            end
            SH_ASR: begin
                r = d >> n;
                for (int b = 0; b < n; b++) r[15-b] = d[15];
                c = (n == 0) ? 1'b0 : d[n-1];
            end
            default: begin
                r = (d >> n) | (d << (16 - n));
                c = 1'b0;
            end
        endcase
        return {c, (r == 16'h0000), r};
    endfunction

    task automatic settle();
        #1;
    endtask

    // Score this cycle's handshakes, then move to just after the next edge.
    task automatic advance();
        exp_t e;
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (in_valid && in_ready) begin
                e.res = model(in_data, in_amt, in_mode);
                e.key = int'({in_mode, in_amt});
                sb.push_back(e);
                acc_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                check("emit_expected", 32'(sb.size() != 0), 1);
                n_emit++;
                emit_cyc = cyc;
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("result", {14'd0, out_carry, out_zero, out_data}, {14'd0, e.res});
                    cov[e.key] = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    initial begin
        vec_t        vecs[10];
        int          lat;
        logic [15:0] held;
        logic [15:0] sw_data[8];
        logic [3:0]  sw_amt[8];
        logic [1:0]  sw_mode[8];
        int          idx;
        int          emit0;
        bit          acc;
        bit          holding;
        int          n_acc;
        int          budget;
        int          k;
        int          ncov;

        vecs[0] = '{16'h8000, 4'd15, SH_ASR, 16'hFFFF, 1'b0, 1'b0};
        vecs[1] = '{16'h0003, 4'd15, SH_LSL, 16'h8000, 1'b1, 1'b0};
        vecs[2] = '{16'hF0F0, 4'd4,  SH_LSR, 16'h0F0F, 1'b0, 1'b0};
        vecs[3] = '{16'h1234, 4'd4,  SH_ROR, 16'h4123, 1'b0, 1'b0};
        vecs[4] = '{16'h0000, 4'd0,  SH_LSL, 16'h0000, 1'b0, 1'b1};
        vecs[5] = '{16'h0000, 4'd0,  SH_ASR, 16'h0000, 1'b0, 1'b1};
        vecs[6] = '{16'h8001, 4'd1,  SH_LSL, 16'h0002, 1'b1, 1'b0};
        vecs[7] = '{16'h0001, 4'd1,  SH_LSR, 16'h0000, 1'b1, 1'b1};
        vecs[8] = '{16'h7FFF, 4'd15, SH_ASR, 16'h0000, 1'b1, 1'b1};
        vecs[9] = '{16'h0001, 4'd1,  SH_ROR, 16'h8000, 1'b0, 1'b0};

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        settle();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_carry", out_carry, 0);
        check("rst_out_zero", out_zero, 0);
        check("rst_in_ready", in_ready, 1);

        // Directed vectors, one at a time, with latency measured in edges
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data  = vecs[i].data;
            in_amt   = vecs[i].amt;
            in_mode  = vecs[i].mode;
            in_valid = 1'b1;
            settle();
            check($sformatf("vec%0d_in_ready", i), in_ready, 1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 20) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check($sformatf("vec%0d_latency", i), lat, 4);
            check($sformatf("vec%0d_data", i), out_data, vecs[i].want_data);
            check($sformatf("vec%0d_carry", i), out_carry, vecs[i].want_carry);
            check($sformatf("vec%0d_zero", i), out_zero, vecs[i].want_zero);
        end
        @(posedge clk);
        #1;

        // Back-to-back stream of 8 with a 3-cycle output stall
        for (int i = 0; i < 8; i++) begin
            sw_data[i] = 16'($urandom);
            sw_amt[i]  = 4'($urandom_range(15));
            sw_mode[i] = 2'($urandom_range(3));
        end
        idx   = 0;
        emit0 = n_emit;
        held  = '0;
        for (int c = 0; c < 30; c++) begin
            in_valid  = (idx < 8);
            in_data   = sw_data[idx % 8];
            in_amt    = sw_amt[idx % 8];
            in_mode   = sw_mode[idx % 8];
            out_ready = !(c >= 6 && c <= 8);
            settle();
            if (c >= 6 && c <= 8) begin
                check($sformatf("stall%0d_out_valid", c), out_valid, 1);
                check($sformatf("stall%0d_in_ready", c), in_ready, 0);
                if (c == 6) held = out_data;
                else check($sformatf("stall%0d_hold", c), out_data, held);
            end
            acc = in_valid && in_ready;
            advance();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        check("stall_accepted", idx, 8);
        check("stall_emitted", n_emit - emit0, 8);

        // Reset while three words are in flight
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 16'($urandom);
            in_amt   = 4'($urandom_range(15));
            in_mode  = 2'($urandom_range(3));
            step();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_carry", out_carry, 0);
        check("mid_rst_out_zero", out_zero, 0);
        emit0    = n_emit;
        in_valid = 1'b1;
        in_data  = 16'h00F0;
        in_amt   = 4'd4;
        in_mode  = SH_LSR;
        settle();
        check("post_rst_in_ready", in_ready, 1);
        advance();
        in_valid = 1'b0;
        for (int i = 0; i < 12; i++) step();
        check("post_rst_emitted", n_emit - emit0, 1);
        check("post_rst_latency", emit_cyc - acc_cyc, 4);

        // Random stream: sweep all 64 amount/mode pairs first, then random
        holding = 1'b0;
        n_acc   = 0;
        budget  = 0;
        emit0   = n_emit;
        while (n_acc < 10000 && budget < 60000) begin
            if (!holding && $urandom_range(3) != 0) begin
                k        = (n_acc < 64) ? n_acc : int'($urandom_range(63));
                in_data  = 16'($urandom);
                in_mode  = 2'(k >> 4);
                in_amt   = 4'(k);
                in_valid = 1'b1;
                holding  = 1'b1;
            end else if (!holding) begin
                in_valid = 1'b0;
            end
            out_ready = 1'($urandom_range(1));
            settle();
            acc = in_valid && in_ready;
            advance();
            if (acc) begin
                n_acc++;
                holding = 1'b0;
            end
            budget++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        check("rand_accepted", n_acc, 10000);
        check("rand_emitted", n_emit - emit0, 10000);
        check("rand_drained", sb.size(), 0);
        ncov = 0;
        for (int i = 0; i < 64; i++) ncov += int'(cov[i]);
        check("rand_coverage", ncov, 64);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
